// File: rtl/icache_responder.sv
// Direct-mapped read-only instruction cache: 0-cycle hits, 32-byte line fills over a 256-bit port.
// Optional macro ICACHE_PERF_EN adds saturating perf_hits / perf_misses counters.
module icache_responder #(
    parameter int S_INDEX = 3,
    parameter int S_TAG   = 27 - S_INDEX
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         instr_read,
    input  logic [31:0]  instr_mem_address,
    input  logic         instr_flush,
    output logic [31:0]  instr_rdata,
    output logic         instr_resp,
    output logic [31:0]  pmem_address,
    output logic         pmem_read,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0]  perf_hits,
    output logic [31:0]  perf_misses
`endif
);

    localparam int SETS = 1 << S_INDEX;

    typedef enum logic {
        IDLE,
        FILL
    } state_t;

    state_t             state_reg, state_next;
    logic [SETS-1:0]    valid_reg, valid_next;
    logic [S_TAG-1:0]   tag_reg  [SETS];
    logic [255:0]       data_reg [SETS];
    logic               discard_reg, discard_next;
    logic [31:0]        line_addr_reg, line_addr_next;

    logic [S_INDEX-1:0] req_index;
    logic [S_TAG-1:0]   req_tag;
    logic [2:0]         req_word;
    logic [S_INDEX-1:0] fill_index;
    logic [S_TAG-1:0]   fill_tag;
    logic               hit;
    logic               lookup_hit;
    logic               start_fill;
    logic               fill_write;
    logic [31:0]        word_mux [8];
    logic               unused_addr_bits;

    assign req_index  = instr_mem_address[4+S_INDEX:5];
    assign req_tag    = instr_mem_address[31:5+S_INDEX];
    assign req_word   = instr_mem_address[4:2];
    assign fill_index = line_addr_reg[4+S_INDEX:5];
    assign fill_tag   = line_addr_reg[31:5+S_INDEX];

    // Byte offset within a word is irrelevant for aligned instruction fetch.
    assign unused_addr_bits = ^instr_mem_address[1:0];

    assign hit        = valid_reg[req_index] && (tag_reg[req_index] == req_tag);
    assign lookup_hit = (state_reg == IDLE) && instr_read && hit;
    assign start_fill = (state_reg == IDLE) && instr_read && !hit;
    assign fill_write = (state_reg == FILL) && pmem_resp;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_word
            assign word_mux[gi] = data_reg[req_index][gi*32 +: 32];
        end

        // Flush wins over a completing fill; a poisoned fill lands invalid.
        for (gi = 0; gi < SETS; gi++) begin : g_valid
            assign valid_next[gi] = instr_flush ? 1'b0 :
                                    (fill_write && (fill_index == S_INDEX'(gi))) ? ~discard_reg :
                                    valid_reg[gi];
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        discard_next   = discard_reg;
        line_addr_next = line_addr_reg;
        instr_resp     = 1'b0;
        instr_rdata    = 32'h0;
        case (state_reg)
            IDLE: begin
                if (lookup_hit) begin
                    instr_resp  = 1'b1;
                    instr_rdata = word_mux[req_word];
                end else if (start_fill) begin
                    state_next     = FILL;
                    line_addr_next = {instr_mem_address[31:5], 5'b0};
                    discard_next   = 1'b0;
                end
            end
            FILL: begin
                if (pmem_resp) begin
                    state_next   = IDLE;
                    discard_next = 1'b0;
                end else if (instr_flush) begin
                    discard_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            valid_reg     <= '0;
            discard_reg   <= 1'b0;
            line_addr_reg <= 32'h0;
        end else begin
            state_reg     <= state_next;
            valid_reg     <= valid_next;
            discard_reg   <= discard_next;
            line_addr_reg <= line_addr_next;
        end
    end

    // Tag and data storage carry no reset; validity alone qualifies them.
    always_ff @(posedge clk) begin
        if (fill_write) begin
            tag_reg[fill_index]  <= fill_tag;
            data_reg[fill_index] <= pmem_rdata;
        end
    end

    assign pmem_read    = (state_reg == FILL);
    assign pmem_address = line_addr_reg;

`ifdef ICACHE_PERF_EN
    logic [31:0] perf_hits_reg, perf_misses_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_hits_reg   <= 32'h0;
            perf_misses_reg <= 32'h0;
        end else begin
            if (lookup_hit && (perf_hits_reg != 32'hFFFF_FFFF)) begin
                perf_hits_reg <= perf_hits_reg + 32'd1;
            end
            if (start_fill && (perf_misses_reg != 32'hFFFF_FFFF)) begin
                perf_misses_reg <= perf_misses_reg + 32'd1;
            end
        end
    end

    assign perf_hits   = perf_hits_reg;
    assign perf_misses = perf_misses_reg;
`endif

endmodule
